// File: rtl/dram_pack.sv
// rtl/dram_pack.sv - shared DRAM request types and default sizes
package dram_pack;

  localparam int DRAM_WORD_W   = 32;
  localparam int DRAM_RQ_DEPTH = 8;

  typedef struct packed {
    logic                   wen;
    logic [DRAM_WORD_W-1:0] addr;
    logic [DRAM_WORD_W-1:0] data;
  } dram_req_t;

endpackage

// File: rtl/dram_req_mem.sv
// rtl/dram_req_mem.sv - request storage array, one write port, head and lookahead read ports
module dram_req_mem
  import dram_pack::*;
#(
  parameter int DEPTH = DRAM_RQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  dram_req_t        wdata,
  input  logic [PTR_W-1:0] raddr_hd,
  input  logic [PTR_W-1:0] raddr_ft,
  output dram_req_t        rdata_hd,
  output dram_req_t        rdata_ft
);

  dram_req_t mem_q [DEPTH];
  dram_req_t mem_d [DEPTH];

  // Entries are never cleared; validity is tracked by the queue's count.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata_hd = mem_q[raddr_hd];
  assign rdata_ft = mem_q[raddr_ft];

endmodule

// File: rtl/dram_request_queue.sv
// rtl/dram_request_queue.sv - in-order DRAM request FIFO with head, lookahead and completion callback
module dram_request_queue
  import dram_pack::*;
#(
  parameter int WORD_W = DRAM_WORD_W,
  parameter int DEPTH  = DRAM_RQ_DEPTH
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       dREN,
  input  logic                       dWEN,
  input  logic [WORD_W-1:0]          memaddr,
  input  logic [WORD_W-1:0]          memstore,
  output logic                       dwait,
  output logic                       rq_valid,
  output logic                       rq_wen,
  output logic [WORD_W-1:0]          ramaddr_rq,
  output logic [WORD_W-1:0]          ramstore_rq,
  output logic                       rq_ft_valid,
  output logic                       rq_ft_wen,
  output logic [WORD_W-1:0]          ramaddr_rq_ft,
  output logic [WORD_W-1:0]          ramstore_rq_ft,
  input  logic                       request_done,
  output logic                       callback_valid,
  output logic                       callback_wen,
  output logic [WORD_W-1:0]          memaddr_callback,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_ft;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cb_valid_q, cb_valid_d;
  logic              cb_wen_q, cb_wen_d;
  logic [WORD_W-1:0] cb_addr_q, cb_addr_d;

  logic      push;
  logic      pop;
  dram_req_t wr_req;
  dram_req_t head;
  dram_req_t ft;

  // Full is taken from the registered count only, so a same-cycle pop never frees a slot.
  assign dwait     = (count_q == CNT_W'(DEPTH));
  assign rq_valid  = (count_q >= CNT_W'(1));
  assign rq_ft_valid = (count_q >= CNT_W'(2));
  assign push      = (dREN | dWEN) & ~dwait;
  assign pop       = request_done & rq_valid;
  assign rd_ptr_ft = rd_ptr_q + PTR_W'(1);

  always_comb begin
    wr_req      = '0;
    wr_req.wen  = dWEN;
    wr_req.addr = memaddr;
    wr_req.data = memstore;
  end

  dram_req_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk      (CLK),
    .we       (push),
    .waddr    (wr_ptr_q),
    .wdata    (wr_req),
    .raddr_hd (rd_ptr_q),
    .raddr_ft (rd_ptr_ft),
    .rdata_hd (head),
    .rdata_ft (ft)
  );

  assign rq_wen         = head.wen;
  assign ramaddr_rq     = head.addr;
  assign ramstore_rq    = head.data;
  assign rq_ft_wen      = ft.wen;
  assign ramaddr_rq_ft  = ft.addr;
  assign ramstore_rq_ft = ft.data;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cb_valid_d = pop;
    cb_wen_d   = cb_wen_q;
    cb_addr_d  = cb_addr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      cb_wen_d  = head.wen;
      cb_addr_d = head.addr;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cb_valid_q <= 1'b0;
      cb_wen_q   <= 1'b0;
      cb_addr_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cb_valid_q <= cb_valid_d;
      cb_wen_q   <= cb_wen_d;
      cb_addr_q  <= cb_addr_d;
    end
  end

  assign callback_valid   = cb_valid_q;
  assign callback_wen     = cb_wen_q;
  assign memaddr_callback = cb_addr_q;
  assign occupancy        = count_q;

endmodule

// File: tb/tb_dram_request_queue.sv
// tb/tb_dram_request_queue.sv - randomized self-checking bench for dram_request_queue
module tb_dram_request_queue;

  localparam int W = 32;
  localparam int D = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          dREN, dWEN, request_done;
  logic [W-1:0]  memaddr, memstore;
  logic          dwait, rq_valid, rq_wen, rq_ft_valid, rq_ft_wen;
  logic [W-1:0]  ramaddr_rq, ramstore_rq, ramaddr_rq_ft, ramstore_rq_ft;
  logic          callback_valid, callback_wen;
  logic [W-1:0]  memaddr_callback;
  logic [$clog2(D):0] occupancy;

  always #5 CLK = ~CLK;

  dram_request_queue #(.WORD_W(W), .DEPTH(D)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .dREN             (dREN),
    .dWEN             (dWEN),
    .memaddr          (memaddr),
    .memstore         (memstore),
    .dwait            (dwait),
    .rq_valid         (rq_valid),
    .rq_wen           (rq_wen),
    .ramaddr_rq       (ramaddr_rq),
    .ramstore_rq      (ramstore_rq),
    .rq_ft_valid      (rq_ft_valid),
    .rq_ft_wen        (rq_ft_wen),
    .ramaddr_rq_ft    (ramaddr_rq_ft),
    .ramstore_rq_ft   (ramstore_rq_ft),
    .request_done     (request_done),
    .callback_valid   (callback_valid),
    .callback_wen     (callback_wen),
    .memaddr_callback (memaddr_callback),
    .occupancy        (occupancy)
  );

  typedef struct {
    bit        wen;
    bit [31:0] addr;
    bit [31:0] data;
  } req_t;

  req_t      mq[$];
  bit        exp_cbv;
  bit        exp_cbw;
  bit [31:0] exp_cba;
  int        n_checks = 0;
  int        n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_state();
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("rq_valid", 64'(rq_valid), 64'(mq.size() >= 1));
    chk("rq_ft_valid", 64'(rq_ft_valid), 64'(mq.size() >= 2));
    if (mq.size() >= 1) begin
      chk("rq_wen", 64'(rq_wen), 64'(mq[0].wen));
      chk("ramaddr_rq", 64'(ramaddr_rq), 64'(mq[0].addr));
      chk("ramstore_rq", 64'(ramstore_rq), 64'(mq[0].data));
    end
    if (mq.size() >= 2) begin
      chk("rq_ft_wen", 64'(rq_ft_wen), 64'(mq[1].wen));
      chk("ramaddr_rq_ft", 64'(ramaddr_rq_ft), 64'(mq[1].addr));
      chk("ramstore_rq_ft", 64'(ramstore_rq_ft), 64'(mq[1].data));
    end
    chk("callback_valid", 64'(callback_valid), 64'(exp_cbv));
    chk("callback_wen", 64'(callback_wen), 64'(exp_cbw));
    chk("memaddr_callback", 64'(memaddr_callback), 64'(exp_cba));
  endtask

  // One clock of stimulus: the model applies the queue rules to the pre-edge state.
  task automatic step(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d,
                      input bit done);
    bit full;
    req_t r;
    @(negedge CLK);
    nRST = 1'b1; dREN = rd; dWEN = wr; memaddr = a; memstore = d; request_done = done;
    full = (mq.size() == D);
    #1;
    chk("dwait", 64'(dwait), 64'(full));
    exp_cbv = 1'b0;
    if (done && mq.size() > 0) begin
      exp_cbv = 1'b1;
      exp_cbw = mq[0].wen;
      exp_cba = mq[0].addr;
      void'(mq.pop_front());
    end
    if ((rd || wr) && !full) begin
      r.wen = wr; r.addr = a; r.data = d;
      mq.push_back(r);
    end
    @(posedge CLK);
    #1;
    check_state();
  endtask

  task automatic do_reset(input int cycles, input bit done);
    @(negedge CLK);
    nRST = 1'b0; dREN = 1'b1; dWEN = 1'b0; request_done = done;
    memaddr = 32'h44; memstore = 32'h0;
    repeat (cycles) @(posedge CLK);
    #1;
    mq.delete();
    exp_cbv = 1'b0; exp_cbw = 1'b0; exp_cba = '0;
    check_state();
    chk("dwait_reset", 64'(dwait), 64'(0));
  endtask

  task automatic idle(input bit done);
    step(1'b0, 1'b0, 32'h0, 32'h0, done);
  endtask

  initial begin
    nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; request_done = 1'b0;
    memaddr = '0; memstore = '0;
    exp_cbv = 1'b0; exp_cbw = 1'b0; exp_cba = '0;

    do_reset(2, 1'b0);

    step(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("single_head_addr", 64'(ramaddr_rq), 64'h100);
    idle(1'b1);
    chk("single_cb_addr", 64'(memaddr_callback), 64'h100);

    step(1'b0, 1'b1, 32'h200, 32'hDEAD, 1'b0);
    step(1'b1, 1'b0, 32'h204, 32'h0, 1'b0);
    chk("look_ft_addr", 64'(ramaddr_rq_ft), 64'h204);
    chk("look_head_data", 64'(ramstore_rq), 64'hDEAD);
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 32'(i * 4), 32'(i), 1'b0);
    chk("full_occ", 64'(occupancy), 64'(D));
    step(1'b1, 1'b0, 32'h20, 32'h99, 1'b0);
    step(1'b1, 1'b0, 32'h20, 32'h99, 1'b1);
    step(1'b1, 1'b0, 32'h20, 32'h99, 1'b0);
    for (int i = 0; i < D; i++) idle(1'b1);
    chk("full_last_cb", 64'(memaddr_callback), 64'h20);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h1000 + 32'(i * 4), $urandom, 1'b0);
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, 1'b1, 32'h2000 + 32'(i * 4), $urandom, 1'b1);
    chk("pushpop_occ", 64'(occupancy), 64'(3));
    for (int i = 0; i < 3; i++) idle(1'b1);

    idle(1'b1);
    step(1'b1, 1'b1, 32'h300, 32'h55, 1'b0);
    chk("both_wen", 64'(rq_wen), 64'(1));
    idle(1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h400 + 32'(i * 4), $urandom, 1'b0);
    do_reset(1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      bit req, wr, rd;
      req = ($urandom_range(0, 9) < 6);
      wr  = req && ($urandom_range(0, 1) == 1);
      rd  = req && (!wr || ($urandom_range(0, 3) == 0));
      step(rd, wr, $urandom, $urandom, $urandom_range(0, 9) < 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
